fifo_p3o1: RTL

- FIFO that accepts up to 3 words per write (push 3) and returns 1 word per read (out 1).
- Serialises 3-wide result groups, such as the three per-column partial sums of a 3-tap convolution row, into a single-word stream for the output/writeback path.
- It is the write-wide, read-narrow counterpart of the team's pop-1-out-3 window FIFO.

---
 rtl/fifo_p3o1.sv | 123 ++++++++++++
 1 files changed

// File: rtl/fifo_p3o1.sv
// Write-wide/read-narrow FIFO: up to NUM_WDATA words in per beat, one word out per read, strict write order.
// Read data is registered (1 cycle); writes that do not fit are dropped and flagged on wr_ovf; reads on empty return nothing.
module fifo_p3o1 #(
  parameter int NUM_WDATA     = 3,
  parameter int DAT_WIDTH     = 8,
  parameter int FF_DEPTH      = 8,
  parameter int FF_ADDR_WIDTH = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_req,
  input  logic [1:0]                     wr_num,
  input  logic [DAT_WIDTH*NUM_WDATA-1:0] wr_data,
  input  logic                           rd_req,
  output logic [DAT_WIDTH-1:0]           rd_data,
  output logic                           rd_data_val,
  output logic [FF_ADDR_WIDTH:0]         data_counter,
  output logic                           full,
  output logic                           almost_full,
  output logic                           empty,
  output logic                           wr_ovf
);

  localparam int CW = FF_ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FF_DEPTH);
  localparam logic [CW-1:0] NWD_C   = CW'(NUM_WDATA);

  logic [DAT_WIDTH-1:0]     mem_q [FF_DEPTH];
  logic [DAT_WIDTH-1:0]     mem_d [FF_DEPTH];
  logic [CW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [DAT_WIDTH-1:0]     rd_data_q, rd_data_d;
  logic                     rd_val_q, rd_val_d;
  logic                     wr_ovf_q, wr_ovf_d;

  logic [CW-1:0]            free_space;
  logic [CW-1:0]            wr_num_w;
  logic                     num_legal;
  logic                     wr_enb;
  logic                     wr_rej;
  logic                     rd_enb;
  logic [FF_ADDR_WIDTH-1:0] wr_addr;
  logic [FF_ADDR_WIDTH-1:0] rd_addr;

  // Space and occupancy are judged on the pre-cycle count: a same-cycle read never makes room.
  assign free_space = DEPTH_C - cnt_q;
  assign wr_num_w   = CW'(wr_num);
  assign num_legal  = (wr_num_w != '0) && (wr_num_w <= NWD_C);
  assign wr_enb     = wr_req && num_legal && (wr_num_w <= free_space);
  assign wr_rej     = wr_req && (wr_num != 2'd0) && !wr_enb;
  assign rd_enb     = rd_req && !empty;

  assign wr_addr = wr_ptr_q[FF_ADDR_WIDTH-1:0];
  assign rd_addr = rd_ptr_q[FF_ADDR_WIDTH-1:0];

  always_comb begin
    mem_d = mem_q;
    if (wr_enb) begin
      for (int k = 0; k < NUM_WDATA; k++) begin
        if (k < int'(wr_num)) begin
          mem_d[wr_addr + FF_ADDR_WIDTH'(k)] = wr_data[k*DAT_WIDTH +: DAT_WIDTH];
        end
      end
    end
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rd_data_d = '0;
    rd_val_d  = 1'b0;
    wr_ovf_d  = wr_rej;
    if (wr_enb) begin
      wr_ptr_d = wr_ptr_q + wr_num_w;
    end
    if (rd_enb) begin
      rd_ptr_d  = rd_ptr_q + CW'(1);
      rd_data_d = mem_q[rd_addr];
      rd_val_d  = 1'b1;
    end
    cnt_d = cnt_q + (wr_enb ? wr_num_w : '0) - (rd_enb ? CW'(1) : '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      rd_data_q <= '0;
      rd_val_q  <= 1'b0;
      wr_ovf_q  <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      rd_data_q <= rd_data_d;
      rd_val_q  <= rd_val_d;
      wr_ovf_q  <= wr_ovf_d;
    end
  end

  // The extra pointer bit keeps the pointer distance unambiguous, so it must always equal the count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ((wr_ptr_q - rd_ptr_q) == cnt_q);
      assert (cnt_q <= DEPTH_C);
    end
  end

  assign rd_data      = rd_data_q;
  assign rd_data_val  = rd_val_q;
  assign wr_ovf       = wr_ovf_q;
  assign data_counter = cnt_q;
  assign full         = (cnt_q == DEPTH_C);
  assign almost_full  = (free_space < NWD_C);
  assign empty        = (cnt_q == '0);

endmodule
